// File: rtl/updown_cnt_ctrl_if.sv
// updown_cnt_ctrl_if: command handshake bundle for the up/down counter controller.
//   cmd_valid : command offered (master -> slave)
//   cmd_ready : command accepted when high together with cmd_valid at a rising edge (slave -> master)
//   cmd_op    : 00 up, 01 down, 10 load, 11 no-op (master -> slave)
//   cmd_arg   : step count for up/down (0 means 2^W), load value for load (master -> slave)
interface updown_cnt_ctrl_if #(parameter int W = 3) ();
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_op;
   logic [W-1:0] cmd_arg;
   modport master (output cmd_valid, cmd_op, cmd_arg, input cmd_ready);
   modport slave (input cmd_valid, cmd_op, cmd_arg, output cmd_ready);
endinterface

// File: rtl/updown_cnt_ctrl.sv
// updown_cnt_ctrl: command-driven up/down counter with direction turn, load, pause and abort.
//   clk     : sole clock, rising edge
//   rst_n   : asynchronous active-low reset
//   cmd     : command handshake (slave side of updown_cnt_ctrl_if)
//   pause   : freezes stepping while high (RUN only)
//   abort   : ends the current up/down command (TURN/RUN only), wins over pause
//   count   : registered counter value
//   dir     : registered direction, 0 up / 1 down
//   tick    : high in a cycle whose closing edge steps count
//   wrap    : one-cycle pulse after a wrap-around step
//   busy    : high whenever not idle
//   done    : one-cycle completion pulse
//   aborted : high with done when the command was ended by abort
module updown_cnt_ctrl #(parameter int W = 3) (
   input  logic                clk,
   input  logic                rst_n,
   updown_cnt_ctrl_if.slave    cmd,
   input  logic                pause,
   input  logic                abort,
   output logic [W-1:0]        count,
   output logic                dir,
   output logic                tick,
   output logic                wrap,
   output logic                busy,
   output logic                done,
   output logic                aborted
);
   typedef enum logic [2:0] {IDLE, TURN, RUN, LOAD, DONE} state_t;
   state_t     state, state_n;
   // one extra bit so a step count of 2^W fits; also holds the load value
   logic [W:0] rem;
   logic       op_dir;
   logic       ab_flag;
   logic       accept;
   assign cmd.cmd_ready = state == IDLE;
   assign accept        = cmd.cmd_valid && cmd.cmd_ready;
   assign busy          = state != IDLE;
   assign tick          = state == RUN && !pause && !abort;
   assign done          = state == DONE;
   assign aborted       = done && ab_flag;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (accept) state_n = (cmd.cmd_op == 2'b10) ? LOAD :
                                     (cmd.cmd_op == 2'b11) ? DONE :
                                     (cmd.cmd_op[0] != dir) ? TURN : RUN;
         TURN: state_n = abort ? DONE : RUN;
         RUN:  state_n = (abort || (!pause && rem == (W+1)'(1))) ? DONE : RUN;
         LOAD: state_n = DONE;
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         count   <= '0;
         dir     <= 1'b0;
         rem     <= '0;
         op_dir  <= 1'b0;
         ab_flag <= 1'b0;
         wrap    <= 1'b0;
      end else begin
         wrap <= tick && (dir ? count == '0 : count == '1);
         if (accept) begin
            // a zero step count encodes 2^W: the top bit is set exactly then
            rem     <= cmd.cmd_op[1] ? {1'b0, cmd.cmd_arg} : {cmd.cmd_arg == '0, cmd.cmd_arg};
            op_dir  <= cmd.cmd_op[0];
            ab_flag <= 1'b0;
         end
         if (state == TURN && !abort) dir <= op_dir;
         if ((state == TURN || state == RUN) && abort) ab_flag <= 1'b1;
         if (tick) begin
            count <= dir ? count - W'(1) : count + W'(1);
            rem   <= rem - (W+1)'(1);
         end
         if (state == LOAD) count <= rem[W-1:0];
      end
endmodule

// File: tb/tb_updown_cnt_ctrl.sv
// tb_updown_cnt_ctrl: directed and randomized checks of updown_cnt_ctrl against an action-queue model.
module tb_updown_cnt_ctrl;
   localparam int W = 3;
   localparam int M = 1 << W;
   localparam int A_TURN = 1, A_STEP = 2, A_LOAD = 3, A_DONE = 4, A_DONEAB = 5;
   logic clk = 1'b0, rst_n = 1'b0, pause = 1'b0, abort = 1'b0;
   logic [W-1:0] count;
   logic dir, tick, wrap, busy, done, aborted;
   updown_cnt_ctrl_if #(.W(W)) bus ();
   updown_cnt_ctrl #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n), .cmd(bus), .pause(pause), .abort(abort),
      .count(count), .dir(dir), .tick(tick), .wrap(wrap), .busy(busy),
      .done(done), .aborted(aborted)
   );
   always #5 clk = ~clk;
   int checks = 0, errors = 0;
   // model: a command expands into a queue of per-cycle actions
   int q[$];
   int m_cnt = 0, m_dir = 0, m_wrap = 0, m_new_dir = 0, m_load = 0;
   int tick_n = 0, wrap_n = 0, busy_n = 0;
   bit done_seen = 0, ab_seen = 0;
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask
   always @(negedge clk) begin
      int h, e_tick;
      if (!rst_n) begin
         q = {};
         m_cnt = 0; m_dir = 0; m_wrap = 0;
         chk("rst_count", int'(count), 0);
         chk("rst_dir", int'(dir), 0);
         chk("rst_tick", int'(tick), 0);
         chk("rst_wrap", int'(wrap), 0);
         chk("rst_busy", int'(busy), 0);
         chk("rst_done", int'(done), 0);
         chk("rst_aborted", int'(aborted), 0);
         chk("rst_ready", int'(bus.cmd_ready), 1);
      end else begin
         h = (q.size() != 0) ? q[0] : 0;
         e_tick = (h == A_STEP && !pause && !abort) ? 1 : 0;
         chk("count", int'(count), m_cnt);
         chk("dir", int'(dir), m_dir);
         chk("wrap", int'(wrap), m_wrap);
         chk("tick", int'(tick), e_tick);
         chk("busy", int'(busy), h != 0 ? 1 : 0);
         chk("ready", int'(bus.cmd_ready), h == 0 ? 1 : 0);
         chk("done", int'(done), h >= A_DONE ? 1 : 0);
         chk("aborted", int'(aborted), h == A_DONEAB ? 1 : 0);
         tick_n += int'(tick);
         wrap_n += int'(wrap);
         busy_n += int'(busy);
         if (done) begin done_seen = 1; ab_seen = aborted; end
         m_wrap = 0;
         if (h == 0) begin
            if (bus.cmd_valid) begin
               int op, arg;
               op = int'(bus.cmd_op);
               arg = int'(bus.cmd_arg);
               if (op < 2) begin
                  m_new_dir = op;
                  if (op != m_dir) q.push_back(A_TURN);
                  repeat (arg == 0 ? M : arg) q.push_back(A_STEP);
               end else if (op == 2) begin
                  m_load = arg;
                  q.push_back(A_LOAD);
               end
               q.push_back(A_DONE);
            end
         end else if ((h == A_TURN || h == A_STEP) && abort) begin
            q = {A_DONEAB};
         end else if (!(h == A_STEP && pause)) begin
            if (h == A_TURN) m_dir = m_new_dir;
            if (h == A_STEP) begin
               m_wrap = ((m_dir == 0 && m_cnt == M - 1) || (m_dir == 1 && m_cnt == 0)) ? 1 : 0;
               m_cnt = (m_cnt + (m_dir ? M - 1 : 1)) % M;
            end
            if (h == A_LOAD) m_cnt = m_load;
            void'(q.pop_front());
         end
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic issue(input int op, input int arg);
      int k = 0;
      while (!bus.cmd_ready && k < 50) begin step(); k++; end
      tick_n = 0; wrap_n = 0; busy_n = 0; done_seen = 0; ab_seen = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_op = 2'(op);
      bus.cmd_arg = W'(arg);
      step();
      bus.cmd_valid = 1'b0;
   endtask
   task automatic wait_done();
      int k = 0;
      while (!done_seen && k < 100) begin step(); k++; end
      if (!done_seen) chk("done_timeout", 0, 1);
      step();
   endtask
   task automatic run_cmd(input int op, input int arg);
      issue(op, arg);
      wait_done();
   endtask
   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_arg = '0;
      repeat (2) step();
      rst_n = 1'b1;
      // up 3 from reset: no turn, three ticks, done one cycle later
      run_cmd(0, 3);
      chk("r32_count", int'(count), 3);
      chk("r32_ticks", tick_n, 3);
      chk("r32_busy", busy_n, 4);
      chk("r32_ab", int'(ab_seen), 0);
      // down 2 from 1: one turn cycle, 1->0->7 with one wrap
      run_cmd(2, 1);
      chk("load1_count", int'(count), 1);
      run_cmd(1, 2);
      chk("r33_count", int'(count), 7);
      chk("r33_dir", int'(dir), 1);
      chk("r33_wraps", wrap_n, 1);
      chk("r33_ticks", tick_n, 2);
      chk("r33_busy", busy_n, 4);
      // load 6: dir unchanged, no ticks
      run_cmd(2, 6);
      chk("r36_count", int'(count), 6);
      chk("r36_dir", int'(dir), 1);
      chk("r36_ticks", tick_n, 0);
      chk("r36_busy", busy_n, 2);
      // arg 0 means 8 steps: full circle from 5
      run_cmd(2, 5);
      run_cmd(0, 0);
      chk("r34_count", int'(count), 5);
      chk("r34_ticks", tick_n, 8);
      chk("r34_wraps", wrap_n, 1);
      chk("r34_busy", busy_n, 10);
      // pause then abort: two steps taken, aborted with done
      issue(0, 4);
      step();
      pause = 1'b1;
      repeat (3) step();
      pause = 1'b0;
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      wait_done();
      chk("r35_count", int'(count), 7);
      chk("r35_ticks", tick_n, 2);
      chk("r35_ab", int'(ab_seen), 1);
      // reset mid-run of down 5: immediate clear, no done
      issue(1, 5);
      repeat (2) step();
      #2 rst_n = 1'b0;
      #1;
      chk("r36_rst_count", int'(count), 0);
      chk("r36_rst_busy", int'(busy), 0);
      chk("r36_rst_ready", int'(bus.cmd_ready), 1);
      step();
      rst_n = 1'b1;
      repeat (4) step();
      chk("r36_no_done", int'(done_seen), 0);
      for (int i = 0; i < 3000; i++) begin
         bus.cmd_valid = ($urandom_range(0, 2) == 0);
         bus.cmd_op = 2'($urandom_range(0, 3));
         bus.cmd_arg = W'($urandom_range(0, M - 1));
         pause = ($urandom_range(0, 4) == 0);
         abort = ($urandom_range(0, 24) == 0);
         rst_n = ($urandom_range(0, 399) != 0);
         step();
      end
      rst_n = 1'b1;
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/updown_cnt_ctrl.md
UPDOWN_CNT_CTRL -- requirements
Module: updown_cnt_ctrl

Interface
REQ-001 SHALL have parameter W, default 3, counter width and step-count width in bits (W >= 2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid at a rising edge.
REQ-006 SHALL have port cmd_op  input  2  00 count up, 01 count down, 10 load, 11 no-op.
REQ-007 SHALL have port cmd_arg  input  W  step count for ops 00/01 (0 means 2^W); load value for op 10.
REQ-008 SHALL have port pause  input  1  freeze stepping while high.
REQ-009 SHALL have port abort  input  1  terminate current command.
REQ-010 SHALL have port count  output  W  current counter value (registered).
REQ-011 SHALL have port dir  output  1  current direction, 0 up, 1 down (registered).
REQ-012 SHALL have port tick  output  1  high in a cycle whose closing edge steps count.
REQ-013 SHALL have port wrap  output  1  one-cycle pulse in the cycle after a wrap step.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port aborted  output  1  qualifies done; high with done if command ended by abort.

Function
REQ-017 SHALL implement states IDLE, TURN, RUN, LOAD, DONE; cmd_ready = 1 only in IDLE.
REQ-018 IDLE, handshake with op 00/01: latch op direction and remaining = cmd_arg (0 -> 2^W); go TURN if op direction differs from dir, else RUN.
REQ-019 IDLE, handshake with op 10: go LOAD; op 11: go DONE with count/dir unchanged, aborted = 0.
REQ-020 TURN: exactly one cycle, no step; dir takes latched direction at its closing edge; then RUN.
REQ-021 RUN: tick = !pause && !abort; on tick edge count += 1 (up) or -= 1 (down) modulo 2^W, remaining -= 1.
REQ-022 RUN: when the step leaving remaining = 0 occurs, go DONE at the same edge.
REQ-023 Wrap step = up from 2^W-1 to 0 or down from 0 to 2^W-1; wrap high exactly the following cycle.
REQ-024 LOAD: one cycle; count = latched cmd_arg at closing edge, dir unchanged, tick = 0; then DONE.
REQ-025 DONE: done = 1 for exactly one cycle, then IDLE.
REQ-026 abort in TURN or RUN: no step that cycle, count held, dir held (TURN: dir not changed); go DONE with aborted = 1.
REQ-027 abort has priority over pause; abort and pause ignored in IDLE, LOAD, DONE.
REQ-028 pause in RUN: count, remaining, state held; tick = 0; no limit on pause length.
REQ-029 Latency, same direction: accept at edge E0, S steps at edges E1..ES, done high in cycle after ES; direction change adds one cycle.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, count = 0, dir = 0, remaining = 0, tick = 0, wrap = 0, done = 0, aborted = 0, busy = 0, cmd_ready = 1, including mid-command; no done pulse for an interrupted command.
REQ-031 After rst_n deasserts, the first handshake SHALL be accepted at the first rising edge with cmd_valid high.

Verification
REQ-032 Reset, op 00 arg 3 -> no TURN, count 1,2,3 on three consecutive edges, tick high 3 cycles, done one cycle later, aborted 0.
REQ-033 count 1, dir 0, op 01 arg 2 -> one TURN cycle (dir -> 1, tick 0), count 0 then 7, wrap pulse after 0->7 step, done.
REQ-034 W=3, op 00 arg 0 from count 5 -> 8 steps, count returns to 5, one wrap pulse, done.
REQ-035 op 00 arg 4, pause high 3 cycles after first step, abort after second step -> count = start+2, aborted = 1 with done.
REQ-036 op 10 arg 6 -> count 6, dir unchanged, tick never high, done; then rst_n low mid RUN of op 01 arg 5 -> count 0, busy 0 immediately, no done.
